// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage pipelined ALU execute stage built from one-bit slices and 4-bit CLA groups.
// S1 holds operands, the ALU runs between stages, and S2 holds the result and flags.
module alu_slice (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic g,
    output logic p,
    output logic s
);
    assign g = a & b;
    assign p = a | b;
    assign s = a ^ b ^ c;
endmodule

module cla4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       ci,
    output logic [3:0] co
);
    assign co[0] = g[0] | (p[0] & ci);
    assign co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & ci);
endmodule

module alu_exec_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   c;
    logic             ovf;
    logic             less;
    logic             arith;
    logic             accept;
    logic             s2_load;

    assign b_inv = s1_op[2] ? ~s1_b : s1_b;
    assign c[0]  = s1_op[2];

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            alu_slice u_slice (
                .a(s1_a[i]),
                .b(b_inv[i]),
                .c(c[i]),
                .g(g[i]),
                .p(p[i]),
                .s(sum[i])
            );
        end
        // Groups resolve carries internally; the group carry-out ripples into the next group.
        for (i = 0; i < WIDTH / 4; i++) begin : g_cla
            cla4 u_cla (
                .g(g[4*i +: 4]),
                .p(p[4*i +: 4]),
                .ci(c[4*i]),
                .co(c[4*i+1 +: 4])
            );
        end
    endgenerate

    assign ovf   = c[WIDTH] ^ c[WIDTH-1];
    assign less  = sum[WIDTH-1] ^ ovf;
    assign arith = s1_op[1:0] == 2'b10;

    always_comb begin
        result = s1_op[1:0] == 2'b00 ? (s1_a & b_inv) :
                 s1_op[1:0] == 2'b01 ? (s1_a | b_inv) :
                 s1_op[1:0] == 2'b10 ? sum :
                 {{(WIDTH-1){1'b0}}, less};
    end

    assign in_ready  = !s1_valid || !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_load   = s1_valid && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_zero   <= result == '0;
            out_carry  <= arith && c[WIDTH];
            out_ovf    <= arith && ovf;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage.
// Expected results are queued at input handshake and popped at output handshake.
module tb_alu_exec_stage;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_carry;
    logic         out_ovf;

    exp_t q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    bit   rnd_done;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_op(in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_zero(out_zero),
        .out_carry(out_carry),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t         e;
        logic [W-1:0] bi;
        logic [W:0]   s;
        logic         v;
        bi = op[2] ? ~b : b;
        s  = {1'b0, a} + {1'b0, bi} + {{W{1'b0}}, op[2]};
        v  = (a[W-1] == bi[W-1]) && (s[W-1] != a[W-1]);
        case (op[1:0])
            2'b00:   e.r = a & bi;
            2'b01:   e.r = a | bi;
            2'b10:   e.r = s[W-1:0];
            default: e.r = {{(W-1){1'b0}}, s[W-1] ^ v};
        endcase
        e.z = e.r == '0;
        e.c = op[1:0] == 2'b10 ? s[W] : 1'b0;
        e.v = op[1:0] == 2'b10 ? v : 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", out_result, 32'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", out_result, e.r);
                check("zero", out_zero, e.z);
                check("carry", out_carry, e.c);
                check("ovf", out_ovf, e.v);
            end
        end
        if (rst_n && in_valid && in_ready) q.push_back(model(in_a, in_b, in_op));
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n = 0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b1;
        rnd_done = 1'b0;
        #13;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_flags", {out_zero, out_carry, out_ovf}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'h7FFF, 16'h0001, 3'b010);
        check("lat_edge_n", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", out_valid, 1);
        check("add_result", out_result, 32'h8000);
        check("add_ovf", out_ovf, 1);
        drain();

        send(16'h1234, 16'h1234, 3'b110);
        send(16'h8000, 16'h0001, 3'b111);
        send(16'h7FFF, 16'h8000, 3'b111);
        send(16'hF0F0, 16'h3C3C, 3'b000);
        send(16'hF0F0, 16'h3C3C, 3'b001);
        send(16'hF0F0, 16'h3C3C, 3'b100);
        send(16'hFFFF, 16'h0001, 3'b010);
        send(16'h0005, 16'h0003, 3'b011);
        drain();

        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 3'b010);
        send(16'h0002, 16'h0002, 3'b010);
        in_a = 16'h0003;
        in_b = 16'h0003;
        in_op = 3'b010;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", out_result, 32'h0002);
            check("bp_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 3'b010);
        send(16'h3333, 16'h4444, 3'b010);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", out_valid, 0);
        send(16'h0005, 16'h0003, 3'b110);
        drain();

        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [2:0] op;
                    op = 3'($urandom_range(0, 7));
                    send(W'($urandom), W'($urandom), op);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 2) != 0;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-stage pipelined N-bit ALU execute stage. It chains WIDTH one-bit ALU slices through 4-bit carry-lookahead groups, registers operands and results, and adds valid/ready handshakes on both sides. It sits directly downstream of the decode/operand-fetch logic and drives the writeback/flag logic.

## Interface
- WIDTH, 16, datapath width; must be a multiple of 4, minimum 4.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  op code: [2] = binv/subtract, [1:0] selects 00 AND, 01 OR, 10 ADD/SUB, 11 SLT.
- out_valid  out  1  result registers hold an undelivered result.
- out_ready  in  1  downstream accepts this cycle.
- out_result  out  WIDTH  ALU result.
- out_zero  out  1  out_result == 0.
- out_carry  out  1  carry out of MSB (ADD/SUB only, else 0).
- out_ovf  out  1  signed overflow (ADD/SUB only, else 0).

## Operation
- Stage 1 (S1): registers a, b, op, and s1_valid on an input handshake (in_valid & in_ready).
- Combinational ALU from the S1 registers:
  - b' = op[2] ? ~b : b.
  - Slice i: g_i = a_i & b'_i; p_i = a_i | b'_i; sum_i = a_i ^ b'_i ^ c_i.
  - c_0 = op[2].
  - Carries come from the 4-bit CLA groups, rippled group-to-group: c_{i+1} = g_i | p_i & c_i.
- Result selection per op[1:0]:
  - 00: a & b'.
  - 01: a | b'.
  - 10: sum.
  - 11: less; bit 0 = sum_{MSB} ^ ovf, all other bits 0.
- Op combinations 100/101 yield a & ~b and a | ~b. Op 011 (SLT without binv) is legal and computes from a + b; upstream issues 111 for SLT.
- ovf = c_WIDTH ^ c_{WIDTH-1}; carry = c_WIDTH. Both are forced to 0 at the output unless op[1:0] == 10.
- Stage 2 (S2): registers result, zero, carry, ovf, and s2_valid.
- S2 loads when s1_valid & (!s2_valid | out_ready).
- s2_valid clears when a result is delivered (out_valid & out_ready) and no S1 entry moves in.
- S1 is freed when its entry moves to S2.
- in_ready = !s1_valid | !s2_valid | out_ready. This is combinational from out_ready; no other comb path from input to output.
- Reset (any time, including with both stages full):
  - s1_valid and s2_valid clear immediately, so out_valid = 0.
  - out_result = 0, out_zero = 0, out_carry = 0, out_ovf = 0.
  - S1 data registers = 0.
  - In-flight operations are discarded; in_ready = 1 while rst_n is low and after release.

## Timing
- Latency: input handshake at edge N puts the result on the outputs after edge N+1; out_valid is high in cycle N+1 when unstalled.
- Throughput: 1 op/cycle with out_ready held high.
- Buffering: 2 entries total (S1 + S2). Under a stall (out_ready low), two ops are accepted, then in_ready goes low.
- Output stability: out_* are stable while out_valid & !out_ready.
- Simultaneous deliver + load: when S2 delivers and S1 refills S2 on the same edge, out_valid stays high with the new data. When S1 also accepts a new input on that edge, no bubble is inserted.
- Data while idle: outputs may hold stale data when out_valid = 0; the bench checks them only when valid.
- Ordering: strict FIFO; no reordering, no drops.

## Test plan
- ADD: a=0x7FFF, b=0x0001, op=010 → 0x8000, ovf=1, carry=0, zero=0; out_valid rises one edge after acceptance.
- SUB: a=0x1234, b=0x1234, op=110 → 0x0000, zero=1, carry=1, ovf=0.
- SLT:
  - a=0x8000, b=0x0001, op=111 → 0x0001.
  - a=0x7FFF, b=0x8000, op=111 → 0x0000 (overflow-corrected).
  - In both cases carry=0 and ovf=0.
- Logic: a=0xF0F0, b=0x3C3C.
  - op=000 → 0x3030.
  - op=001 → 0xFCFC.
  - op=100 → 0xC0C0, zero=0.
- Backpressure: out_ready=0, issue ops ADD 1+1, 2+2, 3+3 back-to-back.
  - in_ready drops after the 2nd accept; out_result holds 0x0002 stable.
  - Raise out_ready: 0x0002, 0x0004, 0x0006 are delivered in order, with the 3rd accepted the cycle out_ready rises.
- Reset mid-operation: both stages full, pull rst_n low asynchronously between edges.
  - out_valid=0 and out_result=0 immediately; in_ready=1.
  - After release, the first new op returns its correct result with no residue.
